lru_ctrl: RTL
=============

// Module: lru_ctrl
// PURPOSE
//  Replacement-policy controller for the 2-way set-associative cache; the
//  read/update side of the 256-entry LRU bit array. Per cache access it reads
//  the set's LRU bit, selects the way (hit way or victim), and writes back the
//  updated bit. Also sweeps every LRU entry to 0 on a flush request.
//  Sits between the cache FSM and the LRU bit array.
// PARAMETERS
//  INDEX_W   8    set-index width
//  NUM_SETS  256  number of LRU entries swept by flush (= 2**INDEX_W)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst          in   1        asynchronous reset, active-low
//  req_valid    in   1        access request present
//  req_ready    out  1        controller can accept request this cycle
//  req_index    in   INDEX_W  set index of access
//  req_hit0     in   1        tag hit in way 0
//  req_hit1     in   1        tag hit in way 1
//  req_vld0     in   1        way 0 line valid
//  req_vld1     in   1        way 1 line valid
//  rsp_valid    out  1        one-cycle pulse: rsp_way/rsp_hit/err valid
//  rsp_way      out  1        way used (hit way or chosen victim)
//  rsp_hit      out  1        1 = access was a hit
//  err          out  1        pulses with rsp_valid when hit0 & hit1 both set
//  flush        in   1        request full LRU clear (level sampled per cycle)
//  flush_busy   out  1        flush sweep in progress or pending
//  lru_index    out  INDEX_W  address to LRU array (read and write)
//  lru_rdata    in   1        LRU bit at lru_index, combinational same cycle
//  lru_write    out  1        LRU array write enable
//  lru_wdata    out  1        LRU bit to write
// BEHAVIOUR
//  LRU bit meaning: value = way to evict next. After using way w, write ~w.
//  Reset (rst=0): state IDLE, flush_pending=0, sweep counter=0; all outputs 0
//   except req_ready, which follows IDLE rule once rst=1. Reset mid-sweep or
//   mid-access aborts; no response issued; array contents untouched.
//  States: IDLE, LOOKUP, UPDATE, FLUSH.
//  req_ready = (state==IDLE) & ~flush & ~flush_pending.
//  IDLE: req_valid&req_ready -> latch index/hits/valids, go LOOKUP.
//   flush|flush_pending -> clear pending, counter=0, go FLUSH (flush wins
//   over simultaneous req_valid; request stays unaccepted).
//  LOOKUP (1 cyc): lru_index=latched index, lru_write=0. Way select:
//   hit0 -> way0 (err=1 if hit1 too); else hit1 -> way1;
//   else ~vld0 -> way0; else ~vld1 -> way1; else lru_rdata. Register, go UPDATE.
//  UPDATE (1 cyc): lru_index=latched index, lru_write=1, lru_wdata=~way;
//   rsp_valid=1 with rsp_way, rsp_hit=hit0|hit1, err. Go IDLE.
//  Latency: accept edge N -> rsp_valid high during cycle N+2; throughput 1 per
//   3 cycles. No response back-pressure.
//  flush during LOOKUP/UPDATE: set flush_pending; access completes normally.
//  flush during FLUSH: ignored (no restart).
//  FLUSH: each cycle lru_index=counter, lru_write=1, lru_wdata=0; counter+1;
//   at counter==NUM_SETS-1 write then go IDLE, counter wraps to 0.
//   Sweep = exactly NUM_SETS write cycles.
//  flush_busy = (state==FLUSH) | flush_pending.
//  Outside LOOKUP/UPDATE/FLUSH: lru_index=0, lru_write=0, lru_wdata=0.
// TESTING
//  1 Miss, both valid, LRU[5]=1: req idx=5 -> rsp_way=1, rsp_hit=0 at N+2;
//    write LRU[5]=0 in UPDATE.
//  2 Hit way1 idx=0xFF, LRU=1 -> rsp_way=1, rsp_hit=1, LRU[0xFF] written 0;
//    repeat miss idx=0xFF both valid -> rsp_way=0.
//  3 Miss, vld0=0, vld1=1, LRU=1 -> rsp_way=0; hit0=hit1=1 -> rsp_way=0, err=1.
//  4 flush pulse in IDLE -> 256 consecutive writes idx 0..255 data 0,
//    req_ready=0 throughout, flush_busy drops after last write.
//  5 flush+req_valid same cycle -> flush taken, req accepted only after sweep;
//    flush during LOOKUP -> rsp issued, then sweep starts next cycle.
//  6 rst low at sweep idx 100 -> all outputs 0 immediately; after release,
//    req_ready=1, no residual writes.

Source files
------------

// File: rtl/lru_ctrl.sv
// LRU replacement controller for a 2-way set-associative cache.
// Selects the hit way or a victim per access, updates the set's LRU bit, and sweeps the array on flush.
module lru_ctrl #(
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned NUM_SETS = 2**INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INDEX_W-1:0] req_index,
  input  logic               req_hit0,
  input  logic               req_hit1,
  input  logic               req_vld0,
  input  logic               req_vld1,
  output logic               rsp_valid,
  output logic               rsp_way,
  output logic               rsp_hit,
  output logic               err,
  input  logic               flush,
  output logic               flush_busy,
  output logic [INDEX_W-1:0] lru_index,
  input  logic               lru_rdata,
  output logic               lru_write,
  output logic               lru_wdata
);

  localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(NUM_SETS - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, FLUSH} state_t;

  state_t             state_q, state_d;
  logic               pending_q, pending_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic               hit0_q, hit0_d, hit1_q, hit1_d;
  logic               vld0_q, vld0_d, vld1_q, vld1_d;
  logic               way_q, way_d;
  logic               err_q, err_d;

  // State and access-context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
      hit0_q    <= 1'b0;
      hit1_q    <= 1'b0;
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      way_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      hit0_q    <= hit0_d;
      hit1_q    <= hit1_d;
      vld0_q    <= vld0_d;
      vld1_q    <= vld1_d;
      way_q     <= way_d;
      err_q     <= err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    hit0_d     = hit0_q;
    hit1_d     = hit1_q;
    vld0_d     = vld0_q;
    vld1_d     = vld1_q;
    way_d      = way_q;
    err_d      = err_q;
    req_ready  = rst & (state_q == IDLE) & ~flush & ~pending_q;
    flush_busy = (state_q == FLUSH) | pending_q;
    rsp_valid  = 1'b0;
    rsp_way    = 1'b0;
    rsp_hit    = 1'b0;
    err        = 1'b0;
    lru_index  = '0;
    lru_write  = 1'b0;
    lru_wdata  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A flush request takes priority over a simultaneous access
        if (flush || pending_q) begin
          pending_d = 1'b0;
          cnt_d     = '0;
          state_d   = FLUSH;
        end else if (req_valid && req_ready) begin
          idx_d   = req_index;
          hit0_d  = req_hit0;
          hit1_d  = req_hit1;
          vld0_d  = req_vld0;
          vld1_d  = req_vld1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        lru_index = idx_q;
        pending_d = pending_q | flush;
        err_d     = hit0_q & hit1_q;
        if (hit0_q)       way_d = 1'b0;
        else if (hit1_q)  way_d = 1'b1;
        else if (!vld0_q) way_d = 1'b0;
        else if (!vld1_q) way_d = 1'b1;
        else              way_d = lru_rdata;
        state_d = UPDATE;
      end
      UPDATE: begin
        // LRU bit names the way to evict next, so point it away from the used way
        lru_index = idx_q;
        lru_write = 1'b1;
        lru_wdata = ~way_q;
        rsp_valid = 1'b1;
        rsp_way   = way_q;
        rsp_hit   = hit0_q | hit1_q;
        err       = err_q;
        pending_d = pending_q | flush;
        state_d   = IDLE;
      end
      FLUSH: begin
        lru_index = cnt_q;
        lru_write = 1'b1;
        lru_wdata = 1'b0;
        cnt_d     = cnt_q + INDEX_W'(1);
        if (cnt_q == LAST_SET) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
